// File: rtl/fp_mult_pkg.sv
// Shared types and constant helpers for the pipelined floating-point multiplier.
// Geometry-independent definitions only; width-dependent payloads are built on top of op_ctl_t.
package fp_mult_pkg;

  localparam int FP_MAX_W = 128;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  typedef enum logic [1:0] {
    KIND_NORM,
    KIND_ZERO,
    KIND_INF,
    KIND_NAN
  } kind_t;

  // Control fields common to every stage payload
  typedef struct packed {
    logic  valid;
    logic  sign;
    kind_t kind;
    logic  invalid;
  } op_ctl_t;

  function automatic int fp_word_w(input int exp_w, input int man_w);
    return 1 + exp_w + man_w;
  endfunction

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_inf(input int exp_w, input int man_w);
    return ((FP_MAX_W'(1) << exp_w) - FP_MAX_W'(1)) << man_w;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (FP_MAX_W'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_delay_line.sv
// Register chain of DEPTH stages with clock enable and synchronous clear; DEPTH=0 is a wire.
// Latency DEPTH enabled cycles; ce=0 freezes every stage.
module fp_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : gen_pass
    assign dout = din;
  end else begin : gen_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clock) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else if (ce) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// IEEE-754 multiplier: unpack, multiply, normalise, RNE round/pack, then EXTRA_DELAY registers.
// Latency 4+EXTRA_DELAY enabled cycles; one op per enabled cycle; ce=0 stalls the whole pipe.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W       = 8,
  parameter int MAN_W       = 23,
  parameter int EXTRA_DELAY = 4,
  parameter int TAG_W       = 4,
  localparam int W          = fp_word_w(EXP_W, MAN_W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [W-1:0]     product,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags
);

  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int XE_W   = EXP_W + 2;
  localparam int DL_W   = 1 + TAG_W + 4 + W;

  localparam logic [XE_W-1:0] BIAS_X  = XE_W'(fp_bias(EXP_W));
  localparam logic [XE_W-1:0] EMAX_X  = XE_W'((1 << EXP_W) - 1);
  localparam logic [W-1:0]    QNAN    = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-2:0]    INF_MAG = (W-1)'(fp_inf(EXP_W, MAN_W));

  typedef struct packed {
    op_ctl_t          ctl;
    logic [TAG_W-1:0] tag;
    logic [XE_W-1:0]  exp;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;
  } s1_t;

  typedef struct packed {
    op_ctl_t           ctl;
    logic [TAG_W-1:0]  tag;
    logic [XE_W-1:0]   exp;
    logic [PROD_W-1:0] prod;
  } s2_t;

  // Normalised significand with the hidden one dropped
  typedef struct packed {
    op_ctl_t           ctl;
    logic [TAG_W-1:0]  tag;
    logic [XE_W-1:0]   exp;
    logic [PROD_W-2:0] frac;
  } s3_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;

  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, snan_a, snan_b;

  assign exp_a  = a[W-2:MAN_W];
  assign exp_b  = b[W-2:MAN_W];
  assign frac_a = a[MAN_W-1:0];
  assign frac_b = b[MAN_W-1:0];

  // Subnormals classify as zero (exponent field zero regardless of fraction)
  always_comb begin
    zero_a = (exp_a == '0);
    zero_b = (exp_b == '0);
    inf_a  = (exp_a == '1) && (frac_a == '0);
    inf_b  = (exp_b == '1) && (frac_b == '0);
    nan_a  = (exp_a == '1) && (frac_a != '0);
    nan_b  = (exp_b == '1) && (frac_b != '0);
    snan_a = nan_a && !frac_a[MAN_W-1];
    snan_b = nan_b && !frac_b[MAN_W-1];

    s1_d             = '0;
    s1_d.ctl.valid   = in_valid;
    s1_d.ctl.sign    = a[W-1] ^ b[W-1];
    s1_d.tag         = in_tag;
    s1_d.exp         = {2'b00, exp_a} + {2'b00, exp_b} - BIAS_X;
    s1_d.sig_a       = {1'b1, frac_a};
    s1_d.sig_b       = {1'b1, frac_b};
    if (nan_a || nan_b) begin
      s1_d.ctl.kind    = KIND_NAN;
      s1_d.ctl.invalid = snan_a | snan_b;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      s1_d.ctl.kind    = KIND_NAN;
      s1_d.ctl.invalid = 1'b1;
    end else if (inf_a || inf_b) begin
      s1_d.ctl.kind    = KIND_INF;
    end else if (zero_a || zero_b) begin
      s1_d.ctl.kind    = KIND_ZERO;
    end else begin
      s1_d.ctl.kind    = KIND_NORM;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)   s1_q <= '0;
    else if (ce) s1_q <= s1_d;
  end

  always_comb begin
    s2_d      = '0;
    s2_d.ctl  = s1_q.ctl;
    s2_d.tag  = s1_q.tag;
    s2_d.exp  = s1_q.exp;
    s2_d.prod = {{SIG_W{1'b0}}, s1_q.sig_a} * {{SIG_W{1'b0}}, s1_q.sig_b};
  end

  always_ff @(posedge clock) begin
    if (reset)   s2_q <= '0;
    else if (ce) s2_q <= s2_d;
  end

  // Product of two [1,2) significands lies in [1,4): at most one right shift
  always_comb begin
    s3_d      = '0;
    s3_d.ctl  = s2_q.ctl;
    s3_d.tag  = s2_q.tag;
    s3_d.exp  = s2_q.exp + {{(XE_W-1){1'b0}}, s2_q.prod[PROD_W-1]};
    s3_d.frac = s2_q.prod[PROD_W-1] ? s2_q.prod[PROD_W-2:0]
                                    : {s2_q.prod[PROD_W-3:0], 1'b0};
  end

  always_ff @(posedge clock) begin
    if (reset)   s3_q <= '0;
    else if (ce) s3_q <= s3_d;
  end

  logic [MAN_W-1:0] mant;
  logic [MAN_W:0]   mant_r;
  logic [XE_W-1:0]  exp_r;
  logic             guard, sticky, rnd_up;
  logic [3:0]       flags_d;
  logic [W-1:0]     product_d;

  always_comb begin
    mant      = s3_q.frac[PROD_W-2 -: MAN_W];
    guard     = s3_q.frac[MAN_W];
    sticky    = |s3_q.frac[MAN_W-1:0];
    rnd_up    = guard & (sticky | mant[0]);
    mant_r    = {1'b0, mant} + {{MAN_W{1'b0}}, rnd_up};
    exp_r     = s3_q.exp + {{(XE_W-1){1'b0}}, mant_r[MAN_W]};
    flags_d   = '0;
    product_d = '0;
    case (s3_q.ctl.kind)
      KIND_NAN: begin
        product_d              = QNAN;
        flags_d[FLAG_INVALID]  = s3_q.ctl.invalid;
      end
      KIND_INF:  product_d = {s3_q.ctl.sign, INF_MAG};
      KIND_ZERO: product_d = {s3_q.ctl.sign, {(W-1){1'b0}}};
      default: begin
        if (!exp_r[XE_W-1] && (exp_r >= EMAX_X)) begin
          product_d               = {s3_q.ctl.sign, INF_MAG};
          flags_d[FLAG_OVERFLOW]  = 1'b1;
          flags_d[FLAG_INEXACT]   = 1'b1;
        end else if (exp_r[XE_W-1] || (exp_r == '0)) begin
          product_d               = {s3_q.ctl.sign, {(W-1){1'b0}}};
          flags_d[FLAG_UNDERFLOW] = 1'b1;
          flags_d[FLAG_INEXACT]   = 1'b1;
        end else begin
          product_d               = {s3_q.ctl.sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
          flags_d[FLAG_INEXACT]   = guard | sticky;
        end
      end
    endcase
    if (!s3_q.ctl.valid) flags_d = '0;
  end

  logic             s4_valid;
  logic [TAG_W-1:0] s4_tag;
  logic [3:0]       s4_flags;
  logic [W-1:0]     s4_product;

  always_ff @(posedge clock) begin
    if (reset) begin
      s4_valid   <= 1'b0;
      s4_tag     <= '0;
      s4_flags   <= '0;
      s4_product <= '0;
    end else if (ce) begin
      s4_valid   <= s3_q.ctl.valid;
      s4_tag     <= s3_q.tag;
      s4_flags   <= flags_d;
      s4_product <= product_d;
    end
  end

  logic [DL_W-1:0] dl_out;

  fp_delay_line #(
    .WIDTH (DL_W),
    .DEPTH (EXTRA_DELAY)
  ) u_align (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .din   ({s4_valid, s4_tag, s4_flags, s4_product}),
    .dout  (dl_out)
  );

  assign {out_valid, out_tag, flags, product} = dl_out;

endmodule
